// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types, digit width and BCD sizing helper for bin_to_bcd_seq
package bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

    localparam int DIGIT_W = 4;

    // Bits of packed BCD needed to show 2^n - 1 in decimal.
    function automatic int bcd_width(input int n);
        longint unsigned v;
        int              d;
        v = (64'd1 << n) - 64'd1;
        d = 0;
        for (int i = 0; i < 20; i++) begin
            if (v != 64'd0) begin
                d = d + 1;
                v = v / 64'd10;
            end
        end
        return d * DIGIT_W;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - combinational double-dabble digit cell: add 3 when the digit is 5 or more
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit
);

    assign o_digit = (i_digit >= DIGIT_W'(5)) ? (i_digit + DIGIT_W'(3)) : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential shift-and-add-3 binary-to-BCD converter, one bit per clock
// Optional macro BIN_SIGNED_EN: two's complement input, magnitude converted, sign reported on neg.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int N_BIN = 16,
    parameter int N_DIG = 5,
    parameter int CNT_W = $clog2(N_BIN)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [N_BIN-1:0]         bin_in,
    output logic                     busy,
    output logic                     done,
    output logic [DIGIT_W*N_DIG-1:0] bcd_out,
    output logic                     neg
);

    localparam int BCD_W = DIGIT_W * N_DIG;

    generate
        if (BCD_W < bcd_width(N_BIN)) begin : g_width_check
            $error("bin_to_bcd_seq: N_DIG too small for N_BIN");
        end
    endgenerate

    bcd_state_t           r_state;
    bcd_state_t           w_state_next;
    logic [BCD_W-1:0]     r_bcd;
    logic [BCD_W-1:0]     w_bcd_corr;
    logic [N_BIN-1:0]     r_bin;
    logic [N_BIN-1:0]     w_bin_load;
    logic [CNT_W-1:0]     r_cnt;
    logic                 w_last;
    logic [BCD_W+N_BIN-1:0] w_shifted;

    genvar g;
    generate
        for (g = 0; g < N_DIG; g++) begin : g_digit
            bcd_add3 u_add3 (
                .i_digit (r_bcd[g*DIGIT_W +: DIGIT_W]),
                .o_digit (w_bcd_corr[g*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    assign w_shifted = {w_bcd_corr, r_bin} << 1;
    assign w_last    = (r_cnt == CNT_W'(N_BIN - 1));

`ifdef BIN_SIGNED_EN
    logic r_neg_pend;

    // The most negative value negates to itself, which is its correct unsigned magnitude.
    assign w_bin_load = bin_in[N_BIN-1] ? (N_BIN'(0) - bin_in) : bin_in;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_neg_pend <= 1'b0;
            neg        <= 1'b0;
        end else begin
            if (r_state == IDLE && start) begin
                r_neg_pend <= bin_in[N_BIN-1];
            end
            if (r_state == SHIFT && w_last) begin
                neg <= r_neg_pend;
            end
        end
    end
`else
    assign w_bin_load = bin_in;
    assign neg        = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // bcd_out is written only on the final iteration so the display never sees partial digits.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bcd   <= '0;
            r_bin   <= '0;
            r_cnt   <= '0;
            bcd_out <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bin <= w_bin_load;
                        r_bcd <= '0;
                        r_cnt <= '0;
                    end
                end
                SHIFT: begin
                    r_bcd <= w_shifted[BCD_W+N_BIN-1 -: BCD_W];
                    r_bin <= w_shifted[N_BIN-1:0];
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        bcd_out <= w_shifted[BCD_W+N_BIN-1 -: BCD_W];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - self-checking bench for bin_to_bcd_seq against a decimal-arithmetic model
module tb_bin_to_bcd_seq;

    localparam int N_BIN = 16;
    localparam int N_DIG = 5;
    localparam int BCD_W = 4 * N_DIG;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [N_BIN-1:0]  bin_in;
    logic              busy;
    logic              done;
    logic [BCD_W-1:0]  bcd_out;
    logic              neg;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    bin_to_bcd_seq #(.N_BIN(N_BIN), .N_DIG(N_DIG)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .neg     (neg)
    );

    function automatic longint unsigned ref_mag(input logic [N_BIN-1:0] v);
`ifdef BIN_SIGNED_EN
        if (v[N_BIN-1]) return 64'd65536 - 64'(v);
`endif
        return 64'(v);
    endfunction

    function automatic logic ref_neg(input logic [N_BIN-1:0] v);
`ifdef BIN_SIGNED_EN
        return v[N_BIN-1];
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [BCD_W-1:0] ref_bcd(input longint unsigned mag);
        logic [BCD_W-1:0] r;
        longint unsigned  m;
        r = '0;
        m = mag;
        for (int d = 0; d < N_DIG; d++) begin
            r[d*4 +: 4] = 4'(m % 64'd10);
            m = m / 64'd10;
        end
        return r;
    endfunction

    task automatic run_conv(input logic [N_BIN-1:0] v, input bit storm,
                            output int lat, output int busy_cnt,
                            output int done_cnt, output bit held_ok);
        logic [BCD_W-1:0] prev;
        @(negedge clock);
        prev     = bcd_out;
        start    = 1'b1;
        bin_in   = v;
        lat      = -1;
        busy_cnt = 0;
        done_cnt = 0;
        held_ok  = 1'b1;
        @(negedge clock);
        if (busy === 1'b1) busy_cnt++;
        if (bcd_out !== prev) held_ok = 1'b0;
        start  = storm;
        bin_in = N_BIN'($urandom);
        for (int k = 1; k <= N_BIN + 3; k++) begin
            @(negedge clock);
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (lat < 0) lat = k;
            end else if (lat < 0 && bcd_out !== prev) begin
                held_ok = 1'b0;
            end
            if (storm && k <= N_BIN) begin
                start  = 1'b1;
                bin_in = N_BIN'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (bcd_out !== '0) begin errors++; $display("FAIL reset_bcd: got %h expected 00000", bcd_out); end
        checks++; if (neg !== 1'b0) begin errors++; $display("FAIL reset_neg: got %b expected 0", neg); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_directed;
        logic [N_BIN-1:0] tv[4];
        logic [BCD_W-1:0] te[4];
        logic             tn[4];
        int lat, bc, dc;
        bit held;
`ifdef BIN_SIGNED_EN
        tv = '{16'h0000, 16'hFB2E, 16'h8000, 16'h007B};
        te = '{20'h00000, 20'h01234, 20'h32768, 20'h00123};
        tn = '{1'b0, 1'b1, 1'b1, 1'b0};
`else
        tv = '{16'hFFFF, 16'd0, 16'd9999, 16'd10};
        te = '{20'h65535, 20'h00000, 20'h09999, 20'h00010};
        tn = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 4; i++) begin
            run_conv(tv[i], 1'b0, lat, bc, dc, held);
            checks++; if (bcd_out !== te[i]) begin errors++; $display("FAIL dir_bcd[%0d]: got %h expected %h", i, bcd_out, te[i]); end
            checks++; if (neg !== tn[i]) begin errors++; $display("FAIL dir_neg[%0d]: got %b expected %b", i, neg, tn[i]); end
            checks++; if (lat !== N_BIN) begin errors++; $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, lat, N_BIN); end
            checks++; if (bc !== N_BIN) begin errors++; $display("FAIL dir_busy_cycles[%0d]: got %0d expected %0d", i, bc, N_BIN); end
            checks++; if (dc !== 1) begin errors++; $display("FAIL dir_done_pulses[%0d]: got %0d expected 1", i, dc); end
            checks++; if (!held) begin errors++; $display("FAIL dir_hold[%0d]: bcd_out changed before done", i); end
        end
    endtask

    task automatic test_random;
        logic [N_BIN-1:0] v;
        int lat, bc, dc;
        bit held;
        for (int i = 0; i < 12; i++) begin
            v = N_BIN'($urandom);
            run_conv(v, 1'b0, lat, bc, dc, held);
            checks++; if (bcd_out !== ref_bcd(ref_mag(v))) begin errors++; $display("FAIL rnd_bcd[%h]: got %h expected %h", v, bcd_out, ref_bcd(ref_mag(v))); end
            checks++; if (neg !== ref_neg(v)) begin errors++; $display("FAIL rnd_neg[%h]: got %b expected %b", v, neg, ref_neg(v)); end
            checks++; if (lat !== N_BIN || dc !== 1) begin errors++; $display("FAIL rnd_timing[%h]: latency %0d pulses %0d expected %0d and 1", v, lat, dc, N_BIN); end
            checks++; if (!held) begin errors++; $display("FAIL rnd_hold[%h]: bcd_out changed before done", v); end
        end
    endtask

    task automatic test_start_ignored;
        logic [N_BIN-1:0] v;
        int lat, bc, dc;
        bit held;
        for (int i = 0; i < 3; i++) begin
            v = N_BIN'($urandom);
            run_conv(v, 1'b1, lat, bc, dc, held);
            checks++; if (bcd_out !== ref_bcd(ref_mag(v))) begin errors++; $display("FAIL storm_bcd[%h]: got %h expected %h", v, bcd_out, ref_bcd(ref_mag(v))); end
            checks++; if (dc !== 1) begin errors++; $display("FAIL storm_done_pulses[%h]: got %0d expected 1", v, dc); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL storm_idle_after: busy got %b expected 0", busy); end
        end
    endtask

    task automatic test_reset_mid;
        int dc, lat, bc;
        bit held;
        dc = 0;
        @(negedge clock);
        start  = 1'b1;
        bin_in = 16'd12345;
        @(negedge clock);
        start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            if (done === 1'b1) dc++;
        end
        reset = 1'b1;
        @(negedge clock);
        checks++; if (bcd_out !== '0) begin errors++; $display("FAIL midrst_bcd: got %h expected 00000", bcd_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (neg !== 1'b0) begin errors++; $display("FAIL midrst_neg: got %b expected 0", neg); end
        if (done === 1'b1) dc++;
        reset = 1'b0;
        for (int k = 0; k < N_BIN + 4; k++) begin
            @(negedge clock);
            if (done === 1'b1) dc++;
        end
        checks++; if (dc !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", dc); end
        run_conv(16'd4321, 1'b0, lat, bc, dc, held);
        checks++; if (bcd_out !== 20'h04321) begin errors++; $display("FAIL midrst_after_bcd: got %h expected 04321", bcd_out); end
        checks++; if (lat !== N_BIN) begin errors++; $display("FAIL midrst_after_latency: got %0d expected %0d", lat, N_BIN); end
    endtask

    task automatic test_back_to_back;
        logic [N_BIN-1:0] v1, v2;
        logic [BCD_W-1:0] first;
        int t, t1, t2;
        v1 = N_BIN'($urandom);
        v2 = N_BIN'($urandom);
        t1 = -1;
        t2 = -1;
        first = '0;
        @(negedge clock);
        start  = 1'b1;
        bin_in = v1;
        @(negedge clock);
        start = 1'b0;
        t = 0;
        while (t1 < 0 && t < N_BIN + 5) begin
            @(negedge clock);
            t++;
            if (done === 1'b1) begin
                t1 = t;
                first = bcd_out;
            end
        end
        checks++; if (t1 !== N_BIN) begin errors++; $display("FAIL b2b_first_latency: got %0d expected %0d", t1, N_BIN); end
        checks++; if (first !== ref_bcd(ref_mag(v1))) begin errors++; $display("FAIL b2b_first_bcd: got %h expected %h", first, ref_bcd(ref_mag(v1))); end
        @(negedge clock);
        t++;
        start  = 1'b1;
        bin_in = v2;
        @(negedge clock);
        t++;
        start = 1'b0;
        while (t2 < 0 && t < N_BIN * 3 + 10) begin
            @(negedge clock);
            t++;
            if (done === 1'b1) t2 = t;
        end
        checks++; if (t2 < 0 || t2 - t1 !== N_BIN + 2) begin errors++; $display("FAIL b2b_spacing: got %0d expected %0d", t2 - t1, N_BIN + 2); end
        checks++; if (bcd_out !== ref_bcd(ref_mag(v2))) begin errors++; $display("FAIL b2b_second_bcd: got %h expected %h", bcd_out, ref_bcd(ref_mag(v2))); end
        repeat (2) @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        test_reset;
        test_directed;
        test_random;
        test_start_ignored;
        test_reset_mid;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
